// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator: compare modes,
// FSM states and the helper that turns the eq/lt/gt flags into the mode result.
package cmp_pkg;

   localparam logic [1:0] MODE_EQ = 2'b00;
   localparam logic [1:0] MODE_NE = 2'b01;
   localparam logic [1:0] MODE_LT = 2'b10;
   localparam logic [1:0] MODE_GT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CMP  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Select the requested relation from the three magnitude flags
   function automatic logic mode_result(input logic [1:0] mode,
                                        input logic eq,
                                        input logic lt,
                                        input logic gt);
      logic res;
      case (mode)
         MODE_EQ: res = eq;
         MODE_NE: res = ~eq;
         MODE_LT: res = lt;
         default: res = gt;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational compare of one STEP-bit chunk: ceq when all bits match,
// clt when a<b as decided by the most significant differing bit.
module chunk_cmp #(
   parameter int STEP = 1
) (
   input  logic [STEP-1:0] a,
   input  logic [STEP-1:0] b,
   output logic            ceq,
   output logic            clt
);

   logic [STEP-1:0] diff;
   logic [STEP-1:0] above_eq;

   assign diff     = a ^ b;
   assign ceq      = ~|diff;
   assign above_eq[STEP-1] = 1'b1;

   // Priority chain: above_eq[i] is set when every bit above i matches
   for (genvar i = STEP - 1; i > 0; i--) begin : g_pri
      assign above_eq[i-1] = above_eq[i] & ~diff[i];
   end

   // The first differing bit from the top decides; a<b when b holds the 1 there
   assign clt = |(diff & b & above_eq);

endmodule

// File: rtl/seq_magnitude_compare.sv
// Sequential magnitude comparator: walks the operands MSB-first, STEP bits per
// clock, stops at the first differing chunk and reports EQ/NE/LT/GT behind a
// start/done handshake. Signed compare is mapped onto unsigned by flipping the
// sign bits at capture time.
module seq_magnitude_compare
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   input  logic             signd,
   output logic             busy,
   output logic             done,
   output logic             r,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int NCHUNK = WIDTH / STEP;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;
   logic [1:0]       mode_q;
   logic [IW-1:0]    idx;
   logic             ceq;
   logic             clt;

   // The operand registers shift left each step, so the chunk under test
   // always sits in the top STEP bits.
   chunk_cmp #(.STEP(STEP)) u_chunk (
      .a   (op_a[WIDTH-1 -: STEP]),
      .b   (op_b[WIDTH-1 -: STEP]),
      .ceq (ceq),
      .clt (clt)
   );

   // Flip both sign bits for a signed compare so that unsigned ordering applies
   always_comb begin
      cap_a = a;
      cap_b = b;
      cap_a[WIDTH-1] = a[WIDTH-1] ^ signd;
      cap_b[WIDTH-1] = b[WIDTH-1] ^ signd;
   end

   // Control FSM with operand capture, chunk walk and registered results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         mode_q <= MODE_EQ;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         r      <= 1'b0;
         eq     <= 1'b0;
         lt     <= 1'b0;
         gt     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_a   <= cap_a;
                  op_b   <= cap_b;
                  mode_q <= mode;
                  idx    <= '0;
                  r      <= 1'b0;
                  eq     <= 1'b0;
                  lt     <= 1'b0;
                  gt     <= 1'b0;
                  busy   <= 1'b1;
                  state  <= ST_CMP;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_CMP: begin
               if (!ceq) begin
                  eq    <= 1'b0;
                  lt    <= clt;
                  gt    <= ~clt;
                  r     <= mode_result(mode_q, 1'b0, clt, ~clt);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (idx == LAST) begin
                  eq    <= 1'b1;
                  lt    <= 1'b0;
                  gt    <= 1'b0;
                  r     <= mode_result(mode_q, 1'b1, 1'b0, 1'b0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx  <= idx + 1'b1;
                  op_a <= op_a << STEP;
                  op_b <= op_b << STEP;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Self-checking bench for seq_magnitude_compare: an 8-bit/1-bit-step instance
// and a 16-bit/4-bit-step instance driven from a directed vector table, a few
// model-checked random vectors, and hand-written multi-cycle sequences.
module tb_seq_magnitude_compare;
   import cmp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start8, start16;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic [1:0]  mode;
   logic        signd;
   logic        busy8, done8, r8, eq8, lt8, gt8;
   logic        busy16, done16, r16, eq16, lt16, gt16;
   logic        sel16;
   logic        busy_s, done_s, r_s, eq_s, lt_s, gt_s;

   int n_compared = 0;
   int n_failed   = 0;

   typedef struct {
      logic        wide;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  mode;
      logic        signd;
      int          c;
      logic        r;
      logic        eq;
      logic        lt;
      logic        gt;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   seq_magnitude_compare #(.WIDTH(8), .STEP(1)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .mode(mode), .signd(signd),
      .busy(busy8), .done(done8), .r(r8), .eq(eq8), .lt(lt8), .gt(gt8)
   );

   seq_magnitude_compare #(.WIDTH(16), .STEP(4)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .mode(mode), .signd(signd),
      .busy(busy16), .done(done16), .r(r16), .eq(eq16), .lt(lt16), .gt(gt16)
   );

   assign busy_s = sel16 ? busy16 : busy8;
   assign done_s = sel16 ? done16 : done8;
   assign r_s    = sel16 ? r16    : r8;
   assign eq_s   = sel16 ? eq16   : eq8;
   assign lt_s   = sel16 ? lt16   : lt8;
   assign gt_s   = sel16 ? gt16   : gt8;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one compare and follow it to done, counting busy cycles
   task automatic applyStimulus(input vec_t v, output int cycles, output logic got_done,
                                output logic flag_err);
      @(negedge clk);
      sel16 = v.wide;
      a8 = v.a[7:0]; b8 = v.b[7:0];
      a16 = v.a; b16 = v.b;
      mode = v.mode; signd = v.signd;
      if (v.wide) start16 = 1'b1;
      else        start8  = 1'b1;
      @(negedge clk);
      start8 = 1'b0; start16 = 1'b0;
      cycles = 0; got_done = 1'b0; flag_err = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (done_s) begin
            got_done = 1'b1;
            break;
         end
         if (busy_s) cycles++;
         if (eq_s | lt_s | gt_s) flag_err = 1'b1;
         @(negedge clk);
      end
   endtask

   // Compare the finished transaction with its expectation, then the pulse width
   task automatic checkResult(input string tag, input vec_t v, input int cycles,
                              input logic got_done, input logic flag_err);
      checkOutput({tag, " done"}, got_done, 1);
      if (got_done) begin
         checkOutput({tag, " cycles"}, cycles, v.c);
         checkOutput({tag, " r"}, r_s, v.r);
         checkOutput({tag, " eq"}, eq_s, v.eq);
         checkOutput({tag, " lt"}, lt_s, v.lt);
         checkOutput({tag, " gt"}, gt_s, v.gt);
         checkOutput({tag, " onehot"}, $onehot({eq_s, lt_s, gt_s}), 1);
         checkOutput({tag, " flags in cmp"}, flag_err, 0);
         @(negedge clk);
         checkOutput({tag, " done pulse"}, done_s, 0);
         checkOutput({tag, " r held"}, r_s, v.r);
      end
   endtask

   // Reference model for 8-bit operands
   task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [1:0] m, output vec_t v);
      logic [7:0] d;
      v.wide = 1'b0; v.a = {8'h00, a}; v.b = {8'h00, b}; v.mode = m; v.signd = s;
      d = a ^ b;
      v.c = 8;
      for (int i = 0; i < 8; i++) if (d[i]) v.c = 8 - i;
      v.eq = (a == b);
      v.lt = s ? ($signed(a) < $signed(b)) : (a < b);
      v.gt = ~v.eq & ~v.lt;
      case (m)
         MODE_EQ: v.r = v.eq;
         MODE_NE: v.r = ~v.eq;
         MODE_LT: v.r = v.lt;
         default: v.r = v.gt;
      endcase
   endtask

   initial begin
      int   cycles;
      logic got, ferr, seen;
      vec_t v;

      vecs[0]  = '{1'b0, 16'h005A, 16'h005A, MODE_EQ, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 16'h0080, 16'h007F, MODE_GT, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 16'h0080, 16'h007F, MODE_GT, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 16'h0012, 16'h0013, MODE_LT, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 16'h0012, 16'h0013, MODE_NE, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 16'h0012, 16'h0013, MODE_EQ, 1'b0, 8, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 16'h00FF, 16'h0001, MODE_LT, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 16'h0000, MODE_NE, 1'b0, 8, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 16'h0040, 16'h0020, MODE_GT, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 16'h1234, 16'h1244, MODE_LT, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 16'hABCD, 16'hABCD, MODE_EQ, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 16'h8000, 16'h0001, MODE_GT, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 16'h1230, 16'h1234, MODE_NE, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0};

      reset = 1'b1; start8 = 1'b0; start16 = 1'b0; sel16 = 1'b0;
      a8 = '0; b8 = '0; a16 = '0; b16 = '0; mode = MODE_EQ; signd = 1'b0;
      #12;
      checkOutput("reset outs 8", {busy8, done8, r8, eq8, lt8, gt8}, 0);
      checkOutput("reset outs 16", {busy16, done16, r16, eq16, lt16, gt16}, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i], cycles, got, ferr);
         checkResult($sformatf("vec%0d", i), vecs[i], cycles, got, ferr);
      end

      for (int i = 0; i < 6; i++) begin
         model8(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), v);
         applyStimulus(v, cycles, got, ferr);
         checkResult($sformatf("rand%0d", i), v, cycles, got, ferr);
      end

      // Start during CMP is ignored; start in the DONE cycle is accepted
      @(negedge clk);
      sel16 = 1'b0; a8 = 8'h12; b8 = 8'h13; mode = MODE_LT; signd = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("b2b busy c1", busy8, 1);
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; mode = MODE_EQ; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cycles = 0; got = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (done8) begin
            got = 1'b1;
            break;
         end
         cycles++;
         @(negedge clk);
      end
      checkOutput("ignored start done", got, 1);
      checkOutput("ignored start latency", cycles, 6);
      checkOutput("ignored start lt", lt8, 1);
      checkOutput("ignored start r", r8, 1);
      checkOutput("ignored start eq", eq8, 0);
      a8 = 8'h01; b8 = 8'h02; mode = MODE_LT; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("b2b done fell", done8, 0);
      checkOutput("b2b busy rose", busy8, 1);
      checkOutput("b2b flags cleared", {eq8, lt8, gt8, r8}, 0);
      cycles = 0; got = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (done8) begin
            got = 1'b1;
            break;
         end
         if (busy8) cycles++;
         @(negedge clk);
      end
      checkOutput("b2b second done", got, 1);
      checkOutput("b2b second cycles", cycles, 7);
      checkOutput("b2b second lt", lt8, 1);
      checkOutput("b2b second r", r8, 1);
      checkOutput("b2b second onehot", $onehot({eq8, lt8, gt8}), 1);

      // Asynchronous reset in the middle of a compare
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h01; mode = MODE_EQ; signd = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort busy before", busy8, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort async outs", {busy8, done8, r8, eq8, lt8, gt8}, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done8 | busy8) seen = 1'b1;
         @(negedge clk);
      end
      checkOutput("abort no done", seen, 0);
      v = '{1'b0, 16'h0001, 16'h0001, MODE_EQ, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0};
      applyStimulus(v, cycles, got, ferr);
      checkResult("after abort", v, cycles, got, ferr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
